beat_generator: RTL
===================

// Module: beat_generator
// PURPOSE
//   Tempo-controlled beat counter feeding the sequencer_player instances. Divides the 10 kHz clock
//   into beat periods and steps a 0..NUM_BEATS-1 beat index used by the players.
//   Handles start/pause/resume and tempo up/down from edge-detected button pulses. While stopped it
//   drives an idle beat code that matches no player slot.
// PARAMETERS
//   NUM_BEATS    8      beats per measure; beat wraps NUM_BEATS-1 -> 0 (2..15)
//   MAX_TICKS    10000  clk ticks per beat at tempo_idx 0 (60 BPM at 10 kHz)
//   TICK_STEP    1000   ticks removed per tempo step; need MAX_TICKS-7*TICK_STEP >= 2
//   DEF_TEMPO    2      tempo_idx after reset (0..7)
//   IDLE_BEAT    4'd15  beat value while stopped; must be >= NUM_BEATS
// PORTS
//   clk           in   1   10 kHz system clock
//   n_rst         in   1   async active-low reset
//   sequencer_on  in   1   1 = sequencer mode; 0 forces STOP
//   play_toggle   in   1   1-cycle pulse: start / pause / resume
//   tempo_up      in   1   1-cycle pulse: tempo_idx +1, saturating at 7
//   tempo_down    in   1   1-cycle pulse: tempo_idx -1, saturating at 0
//   beat          out  4   current beat 0..NUM_BEATS-1, or IDLE_BEAT while STOP
//   beat_strobe   out  1   1-cycle pulse in the same cycle beat takes a new running value
//   measure_start out  1   beat_strobe && beat==0
//   playing       out  1   1 in RUN
//   tempo_idx     out  3   current tempo level
// BEHAVIOUR
//   Clocking/reset: single clk, reset asynchronous and active-low. All outputs are registered except
//     measure_start, which is combinational from the registers.
//   Reset values: state=STOP, beat=IDLE_BEAT, beat_strobe=0, playing=0, tempo_idx=DEF_TEMPO,
//     tick_cnt=0. Reset mid-run aborts immediately to these values.
//   Beat period: period = MAX_TICKS - tempo_idx*TICK_STEP.
//     tick_cnt is 14 bits, unsigned, and sized for MAX_TICKS.
//   FSM states STOP, RUN, PAUSE. Priority is sequencer_on=0 first, then play_toggle.
//     sequencer_on=0, any state -> STOP next cycle: beat=IDLE_BEAT, tick_cnt=0, no strobe.
//     STOP + play_toggle -> RUN: beat=0, tick_cnt=0, beat_strobe=1 in the first RUN cycle.
//     RUN + play_toggle -> PAUSE: beat and tick_cnt hold, no strobe.
//     PAUSE + play_toggle -> RUN: resume from the held tick_cnt and beat. No strobe on resume.
//     play_toggle is ignored while sequencer_on=0.
//   RUN counting:
//     If tick_cnt >= period-1: tick_cnt<=0, beat advances (NUM_BEATS-1 wraps to 0), beat_strobe<=1.
//     Otherwise tick_cnt<=tick_cnt+1 and beat_strobe<=0.
//     The >= compare covers a tempo raised mid-beat: the beat advances on the next cycle, with no
//     underflow or long wait.
//   Tempo:
//     tempo_up and tempo_down act in any state, including STOP and PAUSE.
//     Both pulses in the same cycle: no change. Saturates at 0 and 7 with no wrap.
//     A new tempo takes effect on the next compare cycle; tick_cnt is not reset.
//   Simultaneous play_toggle and beat boundary in RUN: the pause wins; beat and tick_cnt hold
//     (no advance).
//   Output guarantees:
//     beat is never outside 0..NUM_BEATS-1 during RUN or PAUSE.
//     beat_strobe is never high two cycles in a row.
// TESTING (sim overrides MAX_TICKS=20, TICK_STEP=2, DEF_TEMPO=0)
//   1. Reset, sequencer_on=1, no pulses -> beat=15, playing=0, tempo_idx=0 held for 100 cycles.
//   2. play_toggle -> next cycle beat=0, strobe=1, playing=1; at 20-cycle spacing beat=1..7,0;
//      measure_start only when beat=0.
//   3. Pause at tick 5 of beat 3, wait 50 cycles, resume -> beat stays 3 throughout;
//      beat 4 arrives 15 cycles after resume.
//   4. tempo_up x9 -> tempo_idx saturates at 7, period 6 cycles; tempo_down x9 -> 0.
//      Simultaneous up+down -> tempo_idx unchanged.
//   5. At tick_cnt=15, tempo 0 -> 7 -> beat advances the next cycle; later beats every 6 cycles.
//   6. Mid-RUN: sequencer_on=0 -> next cycle beat=15, playing=0. Separately, assert n_rst low
//      mid-beat -> all outputs at reset values immediately, asynchronously.

Source files
------------

// File: rtl/beat_generator.sv
// Tempo-controlled beat counter with start/pause/resume and tempo stepping.
// Outputs an idle beat code while stopped so no player slot matches.
module beat_generator #(
  parameter int          NUM_BEATS = 8,
  parameter int          MAX_TICKS = 10000,
  parameter int          TICK_STEP = 1000,
  parameter int          DEF_TEMPO = 2,
  parameter logic [3:0]  IDLE_BEAT = 4'd15
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sequencer_on,
  input  logic       play_toggle,
  input  logic       tempo_up,
  input  logic       tempo_down,
  output logic [3:0] beat,
  output logic       beat_strobe,
  output logic       measure_start,
  output logic       playing,
  output logic [2:0] tempo_idx
);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_PAUSE
  } state_t;

  localparam logic [13:0] P_MAX  = 14'(MAX_TICKS);
  localparam logic [13:0] P_STEP = 14'(TICK_STEP);
  localparam logic [3:0]  P_LAST = 4'(NUM_BEATS - 1);

  state_t      r_state;
  logic [13:0] r_tick;
  logic [3:0]  r_beat;
  logic        r_strobe;
  logic        r_playing;
  logic [2:0]  r_tempo;

  logic [13:0] w_dec;
  logic [13:0] w_period;
  logic [13:0] w_last;
  logic        w_wrap;
  logic [3:0]  w_beat_nxt;

  assign w_dec      = P_STEP * {11'd0, r_tempo};
  assign w_period   = P_MAX - w_dec;
  assign w_last     = w_period - 14'd1;
  // >= so a tempo raised mid-beat ends the beat at once
  assign w_wrap     = (r_tick >= w_last);
  assign w_beat_nxt = (r_beat == P_LAST) ? 4'd0 : r_beat + 4'd1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_STOP;
      r_tick    <= 14'd0;
      r_beat    <= IDLE_BEAT;
      r_strobe  <= 1'b0;
      r_playing <= 1'b0;
      r_tempo   <= 3'(DEF_TEMPO);
    end else begin
      if (tempo_up && !tempo_down && r_tempo != 3'd7)
        r_tempo <= r_tempo + 3'd1;
      else if (tempo_down && !tempo_up && r_tempo != 3'd0)
        r_tempo <= r_tempo - 3'd1;

      if (!sequencer_on) begin
        r_state   <= ST_STOP;
        r_tick    <= 14'd0;
        r_beat    <= IDLE_BEAT;
        r_strobe  <= 1'b0;
        r_playing <= 1'b0;
      end else begin
        unique case (r_state)
          ST_STOP: begin
            r_strobe <= 1'b0;
            if (play_toggle) begin
              r_state   <= ST_RUN;
              r_tick    <= 14'd0;
              r_beat    <= 4'd0;
              r_strobe  <= 1'b1;
              r_playing <= 1'b1;
            end
          end
          ST_RUN: begin
            if (play_toggle) begin
              r_state   <= ST_PAUSE;
              r_strobe  <= 1'b0;
              r_playing <= 1'b0;
            end else if (w_wrap) begin
              r_tick   <= 14'd0;
              r_beat   <= w_beat_nxt;
              r_strobe <= 1'b1;
            end else begin
              r_tick   <= r_tick + 14'd1;
              r_strobe <= 1'b0;
            end
          end
          ST_PAUSE: begin
            r_strobe <= 1'b0;
            if (play_toggle) begin
              r_state   <= ST_RUN;
              r_playing <= 1'b1;
            end
          end
          default: begin
            r_state   <= ST_STOP;
            r_tick    <= 14'd0;
            r_beat    <= IDLE_BEAT;
            r_strobe  <= 1'b0;
            r_playing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign beat          = r_beat;
  assign beat_strobe   = r_strobe;
  assign playing       = r_playing;
  assign tempo_idx     = r_tempo;
  assign measure_start = r_strobe && (r_beat == 4'd0);

endmodule
